// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencing controller:
// operation codes, controller state encoding and the divide-by-zero LO value.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'b00,
    MULDIV_MULTU = 2'b01,
    MULDIV_DIV   = 2'b10,
    MULDIV_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_WAIT = 2'b01,
    ST_DIV_RUN  = 2'b10,
    ST_DONE     = 2'b11
  } muldiv_state_e;

  // LO value written when a divide sees a zero divisor (HI gets the dividend)
  localparam logic [31:0] DIV_BYPASS_LO = 32'hFFFFFFFF;

  function automatic logic isDivOp(input logic [1:0] kind);
    return (kind == MULDIV_DIV) || (kind == MULDIV_DIVU);
  endfunction

  function automatic logic isSignedOp(input logic [1:0] kind);
    return (kind == MULDIV_MULT) || (kind == MULDIV_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle of the controller's EX-side, multiplier-side and divider-side signals.
// The master modport is the controller; the slave modport is its environment
// (EX stage, HI/LO file, multiplier and divider).
interface muldiv_ctrl_if;

  logic        op_valid;
  logic [1:0]  op_kind;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;

  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;

  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;

  logic        stallreq;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        busy;

  modport master (
    input  op_valid, op_kind, src_a, src_b, flush,
    input  mul_result, div_ready, div_result,
    output mul_signed, mul_ina, mul_inb,
    output div_start, div_signed, div_opa, div_opb, div_annul,
    output stallreq, hilo_we, hi_wdata, lo_wdata, busy
  );

  modport slave (
    output op_valid, op_kind, src_a, src_b, flush,
    output mul_result, div_ready, div_result,
    input  mul_signed, mul_ina, mul_inb,
    input  div_start, div_signed, div_opa, div_opb, div_annul,
    input  stallreq, hilo_we, hi_wdata, lo_wdata, busy
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the fixed-latency multiplier and the iterative
// divider. Accepts one op from EX, holds the pipeline until the result is
// back, then issues a single-cycle HI/LO write. Flush annuls any op in flight.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          resetn,
  muldiv_ctrl_if.master bus
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  muldiv_state_e   r_state;
  muldiv_state_e   w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]     r_opA;
  logic [31:0]     r_opB;
  logic            r_signed;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;

  logic w_accept;
  logic w_bypass;
  logic w_capMul;
  logic w_capDiv;
  logic w_stall;
  logic w_divStart;
  logic w_divAnnul;
  logic w_hiloWe;

  // State register; reset lands in IDLE immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and handshake decode; flush overrides every transition.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_bypass    = 1'b0;
    w_capMul    = 1'b0;
    w_capDiv    = 1'b0;
    w_stall     = 1'b0;
    w_divStart  = 1'b0;
    w_divAnnul  = 1'b0;
    w_hiloWe    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = bus.op_valid & ~bus.flush;
        if (bus.op_valid && !bus.flush) begin
          w_accept = 1'b1;
          if (!isDivOp(bus.op_kind)) begin
            w_stateNext = ST_MUL_WAIT;
          end else if (bus.src_b == 32'd0) begin
            w_bypass    = 1'b1;
            w_stateNext = ST_DONE;
          end else begin
            w_stateNext = ST_DIV_RUN;
          end
        end
      end
      ST_MUL_WAIT: begin
        w_stall = 1'b1;
        if (bus.flush) begin
          w_stateNext = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_capMul    = 1'b1;
          w_stateNext = ST_DONE;
        end
      end
      ST_DIV_RUN: begin
        w_stall = 1'b1;
        if (bus.flush) begin
          w_divAnnul  = 1'b1;
          w_stateNext = ST_IDLE;
        end else if (bus.div_ready) begin
          w_capDiv    = 1'b1;
          w_stateNext = ST_DONE;
        end else begin
          w_divStart = 1'b1;
        end
      end
      ST_DONE: begin
        w_hiloWe    = ~bus.flush;
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Operand latch, multiply latency counter and HI/LO result capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_opA    <= bus.src_a;
        r_opB    <= bus.src_b;
        r_signed <= isSignedOp(bus.op_kind);
        r_cnt    <= CNT_LOAD;
      end else if (r_state == ST_MUL_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_bypass) begin
        r_hi <= bus.src_a;
        r_lo <= DIV_BYPASS_LO;
      end else if (w_capMul) begin
        r_hi <= bus.mul_result[63:32];
        r_lo <= bus.mul_result[31:0];
      end else if (w_capDiv) begin
        r_hi <= bus.div_result[63:32];
        r_lo <= bus.div_result[31:0];
      end
    end
  end

  assign bus.mul_signed = r_signed;
  assign bus.mul_ina    = r_opA;
  assign bus.mul_inb    = r_opB;
  assign bus.div_signed = r_signed;
  assign bus.div_opa    = r_opA;
  assign bus.div_opb    = r_opB;
  assign bus.hi_wdata   = r_hi;
  assign bus.lo_wdata   = r_lo;

  // Strobes are forced low while reset is held, even though IDLE decodes op_valid.
  assign bus.stallreq  = resetn & w_stall;
  assign bus.div_start = resetn & w_divStart;
  assign bus.div_annul = resetn & w_divAnnul;
  assign bus.hilo_we   = resetn & w_hiloWe;
  assign bus.busy      = resetn & (r_state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural multiplier and divider
// models drive the unit side, and expected HI/LO values and stall lengths
// come from plain arithmetic on the requested operation.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int BUDGET  = 200;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   divLat = 33;

  logic [63:0] mulStage;
  int          divCnt;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mulCalc(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint pa, pb;
    if (sgn) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({32'd0, a});
      pb = longint'({32'd0, b});
    end
    return 64'(pa * pb);
  endfunction

  function automatic logic [63:0] divCalc(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint pa, pb, q, r;
    if (b == 32'd0) return 64'hDEAD_BEEF_DEAD_BEEF;
    if (sgn) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({32'd0, a});
      pb = longint'({32'd0, b});
    end
    q = pa / pb;
    r = pa % pb;
    return {32'(r), 32'(q)};
  endfunction

  function automatic logic [63:0] refModel(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b);
    case (kind)
      MULDIV_MULT:  return mulCalc(a, b, 1'b1);
      MULDIV_MULTU: return mulCalc(a, b, 1'b0);
      MULDIV_DIV:   return (b == 32'd0) ? {a, 32'hFFFFFFFF} : divCalc(a, b, 1'b1);
      default:      return (b == 32'd0) ? {a, 32'hFFFFFFFF} : divCalc(a, b, 1'b0);
    endcase
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Multiplier model: product appears MUL_LAT-1 edges after operands settle
  always @(posedge clk) mulStage <= mulCalc(bus.mul_ina, bus.mul_inb, bus.mul_signed);
  assign bus.mul_result = mulStage;

  // Divider model: ready on the divLat-th cycle of a continuous start request
  always @(posedge clk or negedge resetn) begin
    if (!resetn) divCnt <= 0;
    else if (bus.div_start) divCnt <= divCnt + 1;
    else divCnt <= 0;
  end
  assign bus.div_ready  = (divCnt == divLat - 1);
  assign bus.div_result = bus.div_ready ? divCalc(bus.div_opa, bus.div_opb, bus.div_signed)
                                        : 64'h0BAD_0BAD_0BAD_0BAD;

  // Presents one op and holds it until the HI/LO write; ends on a negedge with op_valid low
  task automatic doOp(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b,
                      output int stall, output int starts, output int weSeen,
                      output logic [31:0] hi, output logic [31:0] lo, output bit timedOut);
    bit done;
    stall = 0; starts = 0; weSeen = 0; hi = '0; lo = '0; timedOut = 1'b1; done = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_kind  = kind;
    bus.src_a    = a;
    bus.src_b    = b;
    for (int c = 0; c < BUDGET && !done; c++) begin
      #1;
      if (bus.stallreq) stall++;
      if (bus.div_start) starts++;
      if (bus.hilo_we) begin
        weSeen++;
        hi = bus.hi_wdata;
        lo = bus.lo_wdata;
        done = 1'b1;
        timedOut = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      bus.src_a   = $urandom;
      bus.src_b   = $urandom;
      bus.op_kind = 2'($urandom_range(0, 3));
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.op_valid = 1'b1; bus.op_kind = MULDIV_DIVU; bus.flush = 1'b0;
    bus.src_a = $urandom; bus.src_b = 32'd5;
    resetn = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    checks++;
    if ({bus.stallreq, bus.busy, bus.hilo_we, bus.div_start, bus.div_annul} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes got=%b exp=00000", {bus.stallreq, bus.busy, bus.hilo_we, bus.div_start, bus.div_annul});
    end
    checks++;
    if ({bus.mul_ina, bus.div_opb, bus.hi_wdata, bus.lo_wdata} !== 128'd0) begin
      failures++;
      $display("[TB] FAIL reset_regs ina=%h opb=%h hi=%h lo=%h exp=all zero", bus.mul_ina, bus.div_opb, bus.hi_wdata, bus.lo_wdata);
    end
    bus.op_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult_directed();
    int stall, starts, we; logic [31:0] hi, lo; bit to;
    doOp(MULDIV_MULT, 32'hFFFFFFFD, 32'd5, stall, starts, we, hi, lo, to);
    checks++;
    if (to || we != 1) begin failures++; $display("[TB] FAIL mult_we got=%0d timeout=%0b exp=1", we, to); end
    checks++;
    if (stall != 1 + MUL_LAT) begin failures++; $display("[TB] FAIL mult_stall got=%0d exp=%0d", stall, 1 + MUL_LAT); end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin failures++; $display("[TB] FAIL mult_result got=%h_%h exp=ffffffff_fffffff1", hi, lo); end
    #1;
    checks++;
    if (bus.busy !== 1'b0 || starts != 0) begin failures++; $display("[TB] FAIL mult_after busy=%b starts=%0d exp=0/0", bus.busy, starts); end
    @(negedge clk);
  endtask

  task automatic test_divu_directed();
    int stall, starts, we; logic [31:0] hi, lo; bit to;
    divLat = 33;
    doOp(MULDIV_DIVU, 32'd100, 32'd7, stall, starts, we, hi, lo, to);
    checks++;
    if (to || stall != 34) begin failures++; $display("[TB] FAIL divu_stall got=%0d timeout=%0b exp=34", stall, to); end
    checks++;
    if (starts != 32) begin failures++; $display("[TB] FAIL divu_start got=%0d exp=32", starts); end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin failures++; $display("[TB] FAIL divu_result got=%0d/%0d exp=2/14", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int stall, starts, we; logic [31:0] hi, lo; bit to;
    doOp(MULDIV_DIV, 32'h1234, 32'd0, stall, starts, we, hi, lo, to);
    checks++;
    if (to || stall != 1 || starts != 0) begin
      failures++; $display("[TB] FAIL divzero_stall stall=%0d starts=%0d timeout=%0b exp=1/0/0", stall, starts, to);
    end
    checks++;
    if (hi !== 32'h1234 || lo !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL divzero_result got=%h_%h exp=00001234_ffffffff", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_flush_idle();
    bus.op_valid = 1'b1; bus.op_kind = MULDIV_MULT; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stallreq !== 1'b0) begin failures++; $display("[TB] FAIL flushidle_stall got=%b exp=0", bus.stallreq); end
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0; bus.op_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL flushidle_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
  endtask

  task automatic test_flush_div();
    int runCycles = 0; int weCnt = 0; int badAnnul = 0; bit flushed = 1'b0;
    divLat = 33;
    bus.op_valid = 1'b1; bus.op_kind = MULDIV_DIV; bus.src_a = $urandom; bus.src_b = $urandom | 32'd1;
    for (int c = 0; c < BUDGET && !flushed; c++) begin
      #1;
      if (bus.hilo_we) weCnt++;
      if (bus.div_annul) badAnnul++;
      if (bus.div_start) runCycles++;
      if (runCycles == 10) begin
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.div_annul !== 1'b1) begin failures++; $display("[TB] FAIL flush_annul got=%b exp=1", bus.div_annul); end
        flushed = 1'b1;
      end
      @(posedge clk); @(negedge clk);
    end
    bus.flush = 1'b0; bus.op_valid = 1'b0;
    #1;
    checks++;
    if (!flushed || bus.stallreq !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_idle reached=%0b stall=%b busy=%b exp=1/0/0", flushed, bus.stallreq, bus.busy);
    end
    for (int c = 0; c < 5; c++) begin
      if (bus.hilo_we) weCnt++;
      if (bus.div_annul) badAnnul++;
      @(negedge clk); #1;
    end
    checks++;
    if (weCnt != 0 || badAnnul != 0) begin failures++; $display("[TB] FAIL flush_quiet we=%0d stray_annul=%0d exp=0/0", weCnt, badAnnul); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int stall, starts, we; logic [31:0] hi, lo; bit to;
    divLat = 4;
    doOp(MULDIV_MULT, 32'd7, 32'd8, stall, starts, we, hi, lo, to);
    checks++;
    if (to || stall != 1 + MUL_LAT || {hi, lo} !== 64'd56) begin
      failures++; $display("[TB] FAIL b2b_first stall=%0d result=%h_%h exp=%0d/0_56", stall, hi, lo, 1 + MUL_LAT);
    end
    doOp(MULDIV_DIVU, 32'd9, 32'd2, stall, starts, we, hi, lo, to);
    checks++;
    if (to || we != 1 || stall != 1 + 4) begin failures++; $display("[TB] FAIL b2b_second stall=%0d we=%0d exp=5/1", stall, we); end
    checks++;
    if (hi !== 32'd1 || lo !== 32'd4) begin failures++; $display("[TB] FAIL b2b_result got=%0d/%0d exp=1/4", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int stall, starts, we; logic [31:0] hi, lo, a, b; bit to;
    bus.op_valid = 1'b1; bus.op_kind = MULDIV_MULTU; bus.src_a = $urandom; bus.src_b = $urandom;
    @(posedge clk);
    #2;
    checks++;
    if (bus.stallreq !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre got=%b exp=1", bus.stallreq); end
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.stallreq, bus.busy, bus.hilo_we} !== 3'b0) begin
      failures++; $display("[TB] FAIL arst_drop got=%b exp=000", {bus.stallreq, bus.busy, bus.hilo_we});
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    a = pickVal(); b = pickVal();
    doOp(MULDIV_MULT, a, b, stall, starts, we, hi, lo, to);
    checks++;
    if (to || stall != 1 + MUL_LAT || {hi, lo} !== refModel(MULDIV_MULT, a, b)) begin
      failures++; $display("[TB] FAIL arst_fresh stall=%0d got=%h_%h exp=%0d/%h", stall, hi, lo, 1 + MUL_LAT, refModel(MULDIV_MULT, a, b));
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int stall, starts, we, expStall, expStarts; logic [31:0] hi, lo, a, b; bit to; logic [1:0] kind;
    for (int n = 0; n < 40; n++) begin
      kind = 2'($urandom_range(0, 3));
      a = pickVal();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pickVal();
      divLat = $urandom_range(2, 12);
      if (kind[1] == 1'b0) begin expStall = 1 + MUL_LAT; expStarts = 0; end
      else if (b == 32'd0) begin expStall = 1; expStarts = 0; end
      else begin expStall = 1 + divLat; expStarts = divLat - 1; end
      doOp(kind, a, b, stall, starts, we, hi, lo, to);
      checks++;
      if (to || {hi, lo} !== refModel(kind, a, b)) begin
        failures++; $display("[TB] FAIL rand_result op=%0d a=%h b=%h got=%h_%h exp=%h", kind, a, b, hi, lo, refModel(kind, a, b));
      end
      checks++;
      if (stall != expStall || starts != expStarts) begin
        failures++; $display("[TB] FAIL rand_timing op=%0d stall=%0d starts=%0d exp=%0d/%0d", kind, stall, starts, expStall, expStarts);
      end
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.hilo_we !== 1'b0) begin
        failures++; $display("[TB] FAIL rand_idle busy=%b we=%b exp=0/0", bus.busy, bus.hilo_we);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
    end
  endtask

  // Hard stop in case the design wedges somewhere outside a bounded loop
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence
  initial begin
    bus.op_valid = 1'b0; bus.op_kind = '0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    test_reset();
    test_mult_directed();
    test_divu_directed();
    test_div_zero();
    test_flush_idle();
    test_flush_div();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the EX-stage multiply/divide resources: fixed-latency multiplier and iterative divider with a start/ready handshake.
- Accepts one mult/multu/div/divu op from EX, registers its operands, and drives the selected unit. It holds the pipeline through stallreq until the result is back, then issues a one-cycle HI/LO write.
- Owns divide-by-zero bypass and flush/annul of in-flight ops.

Parameters:
- MUL_LAT, 2, multiplier latency in cycles from operands stable to mul_result valid; legal values are 1 or more.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- op_valid  in  1  EX holds a mul/div op this cycle
- op_kind  in  2  00 mult, 01 multu, 10 div, 11 divu
- src_a  in  32  rs operand (dividend / multiplicand)
- src_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  annul any accepted or in-flight op
- mul_signed  out  1  signed multiply select
- mul_ina  out  32  registered operand a
- mul_inb  out  32  registered operand b
- mul_result  in  64  {hi, lo} product
- div_start  out  1  level start to divider
- div_signed  out  1  signed divide select
- div_opa  out  32  registered dividend
- div_opb  out  32  registered divisor
- div_annul  out  1  abort pulse to divider
- div_ready  in  1  divider result valid
- div_result  in  64  {remainder, quotient}
- stallreq  out  1  hold IF..EX
- hilo_we  out  1  one-cycle HI and LO write strobe
- hi_wdata  out  32  HI write data
- lo_wdata  out  32  LO write data
- busy  out  1  state is not IDLE

Behaviour:
- Reset: resetn low immediately forces state to IDLE and all registered outputs to 0 (operands, hi/lo data, counter). hilo_we, div_start, div_annul, stallreq and busy are 0 while resetn is low.
- States are IDLE, MUL_WAIT, DIV_RUN, DONE.
- IDLE:
  - stallreq = op_valid & ~flush, combinational.
  - On accept, the clock edge latches operands and signedness (op_kind[0]==0 means signed).
  - mult/multu: go to MUL_WAIT and load the counter with MUL_LAT-1.
  - div/divu with src_b==0: go to DONE with hi=src_a, lo=32'hFFFFFFFF; the divider is never started.
  - div/divu with src_b!=0: go to DIV_RUN.
- MUL_WAIT:
  - stallreq=1. mul_ina, mul_inb and mul_signed are stable throughout.
  - The counter decrements each cycle. When the counter is 0, capture mul_result[63:32] into hi and [31:0] into lo, then go to DONE.
  - Total time in MUL_WAIT is exactly MUL_LAT cycles.
- DIV_RUN:
  - stallreq=1 and div_start=1 while div_ready=0.
  - In the cycle div_ready=1: div_start=0; capture hi=div_result[63:32] (remainder) and lo=div_result[31:0] (quotient); go to DONE.
- DONE:
  - hilo_we=1 and stallreq=0 for exactly one cycle, then go to IDLE.
  - The op still present on op_valid this cycle is not re-accepted.
- flush (priority over everything except reset):
  - Any state goes to IDLE next edge, with no hilo_we.
  - div_annul=1 for that cycle if the state is DIV_RUN.
  - In IDLE, flush suppresses the accept.
- Width rules: operands are captured as-is and the controller does no sign extension. Signed and unsigned semantics are delegated to the units via the *_signed outputs.
- Latency (stallreq-high cycles):
  - multiply: 1+MUL_LAT.
  - divide: 1 + (cycles until div_ready).
  - divide by zero: 1.
- op_valid must stay stable while stallreq=1. op_kind or operand changes after accept are ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package/defines holds:
  - op_kind codes (MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU);
  - the state encoding;
  - DIV_BYPASS_LO = 32'hFFFFFFFF.
- Single module. The latency counter is small enough to stay inline, so no sub-module is required.

Test Plan:
- MUL_LAT=2, mult src_a=-3, src_b=5:
  - stallreq high 3 cycles;
  - DONE gives hilo_we=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFF1;
  - stallreq low that cycle.
- divu 100/7, divider model asserting div_ready 33 cycles after div_start:
  - div_start high until ready;
  - hi=2, lo=14;
  - stallreq high 34 cycles.
- div src_a=32'h1234, src_b=0:
  - one stall cycle, div_start never asserted;
  - hi=32'h1234, lo=32'hFFFFFFFF, hilo_we pulse.
- div in progress, flush asserted on 10th DIV_RUN cycle:
  - div_annul=1 that cycle;
  - next cycle state is IDLE, stallreq=0, busy=0;
  - no hilo_we ever issued.
- mult immediately followed by divu 9/2:
  - second op accepted the cycle after DONE;
  - two separate hilo_we pulses, final hi=1, lo=4.
- resetn driven low mid-MUL_WAIT (asynchronous, between edges):
  - stallreq, busy, hilo_we drop at once;
  - after release, the controller is in IDLE and accepts a fresh mult correctly.
